// File: rtl/wrap_seq_checker_pkg.sv
// Shared definitions for the wrapping-sequence checker: state encoding,
// default wrap value and the next-value helper.
package wrap_seq_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_t;

  localparam int DEF_MAX_VAL = 10;

  function automatic int next_val(input int x, input int max_val);
    return (x == max_val) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/wrap_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/wrap_seq_checker.sv
// Receive-side checker for the 0..MAX_VAL wrapping counter stream: locks on,
// tracks the expected next value, and counts out-of-sequence beats.
module wrap_seq_checker
  import wrap_seq_checker_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_VAL       = DEF_MAX_VAL,
  parameter int CNT_WIDTH     = 16,
  parameter int LOCK_THRESH   = 3,
  parameter int UNLOCK_THRESH = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  ivalid,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  clr_cnt,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  oor_pulse,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(UNLOCK_THRESH + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_D = DATA_WIDTH'(MAX_VAL);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] exp_nxt;
  logic [GW-1:0]         good_run, good_nxt;
  logic [BW-1:0]         bad_run, bad_nxt;
  logic                  err_d, oor_d, beat_inc;
  logic                  in_range, match;

  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] x);
    return DATA_WIDTH'(next_val(int'(x), MAX_VAL));
  endfunction

  assign in_range = (idata <= MAX_D);
  assign match    = (idata == exp_data);
  assign locked   = (state == LOCKED) || (state == SLIP);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= HUNT;
      exp_data  <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      err_pulse <= 1'b0;
      oor_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_data  <= exp_nxt;
      good_run  <= good_nxt;
      bad_run   <= bad_nxt;
      err_pulse <= err_d;
      oor_pulse <= oor_d;
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_data;
    good_nxt  = good_run;
    bad_nxt   = bad_run;
    if (ivalid) begin
      unique case (state)
        HUNT: begin
          if (in_range) begin
            exp_nxt   = nxt(idata);
            good_nxt  = GW'(1);
            state_nxt = (LOCK_THRESH == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (!in_range) begin
            good_nxt  = '0;
            state_nxt = HUNT;
          end else if (match) begin
            exp_nxt = nxt(exp_data);
            if (good_run == GW'(LOCK_THRESH - 1)) begin
              good_nxt  = '0;
              state_nxt = LOCKED;
            end else begin
              good_nxt = good_run + GW'(1);
            end
          end else begin
            exp_nxt  = nxt(idata);
            good_nxt = GW'(1);
          end
        end
        LOCKED, SLIP: begin
          // A bad beat is assumed to have consumed one slot of the stream.
          exp_nxt = nxt(exp_data);
          if (match) begin
            bad_nxt   = '0;
            state_nxt = LOCKED;
          end else if ((state == SLIP && bad_run == BW'(UNLOCK_THRESH - 1)) ||
                       (state == LOCKED && UNLOCK_THRESH == 1)) begin
            bad_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            bad_nxt   = (state == LOCKED) ? BW'(1) : bad_run + BW'(1);
            state_nxt = SLIP;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    err_d    = 1'b0;
    oor_d    = 1'b0;
    beat_inc = 1'b0;
    if (ivalid) begin
      oor_d = !in_range;
      if (locked) begin
        beat_inc = 1'b1;
        err_d    = !match;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (err_d),
    .clr     (clr_cnt),
    .count   (err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (beat_inc),
    .clr     (clr_cnt),
    .count   (beat_cnt)
  );

endmodule

// File: tb/tb_wrap_seq_checker.sv
// Directed bench for wrap_seq_checker; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_wrap_seq_checker;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ivalid  = 1'b0;
  logic [7:0] idata   = '0;
  logic       clr_cnt = 1'b0;

  logic        locked, err_pulse, oor_pulse;
  logic [7:0]  exp_data;
  logic [15:0] err_cnt, beat_cnt;
  logic        s_locked, s_err_pulse, s_oor_pulse;
  logic [7:0]  s_exp_data;
  logic [1:0]  s_err_cnt, s_beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wrap_seq_checker #(.DATA_WIDTH(8), .MAX_VAL(10), .CNT_WIDTH(16),
                     .LOCK_THRESH(3), .UNLOCK_THRESH(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ivalid(ivalid), .idata(idata),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .oor_pulse(oor_pulse), .exp_data(exp_data), .err_cnt(err_cnt),
    .beat_cnt(beat_cnt)
  );

  wrap_seq_checker #(.DATA_WIDTH(8), .MAX_VAL(10), .CNT_WIDTH(2),
                     .LOCK_THRESH(3), .UNLOCK_THRESH(2)) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ivalid(ivalid), .idata(idata),
    .clr_cnt(clr_cnt), .locked(s_locked), .err_pulse(s_err_pulse),
    .oor_pulse(s_oor_pulse), .exp_data(s_exp_data), .err_cnt(s_err_cnt),
    .beat_cnt(s_beat_cnt)
  );

  // Drive one cycle of input; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic v, input logic [7:0] d, input logic c = 1'b0);
    ivalid  = v;
    idata   = d;
    clr_cnt = c;
    @(posedge sys_clk);
    #1;
    ivalid  = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0b want 0", err_pulse); end
    checks++; if (oor_pulse !== 1'b0) begin errors++; $display("FAIL reset_oor_pulse got %0b want 0", oor_pulse); end
    checks++; if (exp_data !== 8'd0) begin errors++; $display("FAIL reset_exp_data got %0d want 0", exp_data); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_lock();
    send(1, 0);
    checks++; if (locked !== 1'b0 || exp_data !== 8'd1) begin errors++; $display("FAIL lock_b0 got locked=%0b exp=%0d want 0/1", locked, exp_data); end
    send(1, 1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_b1 got locked=%0b want 0", locked); end
    send(1, 2);
    checks++; if (locked !== 1'b1 || exp_data !== 8'd3) begin errors++; $display("FAIL lock_b2 got locked=%0b exp=%0d want 1/3", locked, exp_data); end
    for (int v = 3; v <= 10; v++) send(1, 8'(v));
    checks++; if (exp_data !== 8'd0 || beat_cnt !== 16'd8) begin errors++; $display("FAIL lock_wrap got exp=%0d beats=%0d want 0/8", exp_data, beat_cnt); end
    send(1, 0);
    send(1, 1);
    checks++; if (exp_data !== 8'd2 || beat_cnt !== 16'd10 || err_cnt !== 16'd0) begin errors++; $display("FAIL lock_post_wrap got exp=%0d beats=%0d errs=%0d want 2/10/0", exp_data, beat_cnt, err_cnt); end
  endtask

  task automatic test_single_err();
    send(1, 2); send(1, 3); send(1, 4);
    send(1, 7);
    checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1 || exp_data !== 8'd6) begin errors++; $display("FAIL single_bad got err=%0b cnt=%0d locked=%0b exp=%0d want 1/1/1/6", err_pulse, err_cnt, locked, exp_data); end
    send(1, 6);
    checks++; if (err_pulse !== 1'b0 || locked !== 1'b1 || exp_data !== 8'd7 || beat_cnt !== 16'd15) begin errors++; $display("FAIL single_recover got err=%0b locked=%0b exp=%0d beats=%0d want 0/1/7/15", err_pulse, locked, exp_data, beat_cnt); end
    send(1, 7);
  endtask

  task automatic test_double_err();
    send(1, 3);
    checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd2 || locked !== 1'b1) begin errors++; $display("FAIL double_first got err=%0b cnt=%0d locked=%0b want 1/2/1", err_pulse, err_cnt, locked); end
    send(1, 3);
    checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd3 || locked !== 1'b0 || beat_cnt !== 16'd18) begin errors++; $display("FAIL double_second got err=%0b cnt=%0d locked=%0b beats=%0d want 1/3/0/18", err_pulse, err_cnt, locked, beat_cnt); end
    send(1, 4);
    send(1, 5);
    checks++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL relock_early got locked=%0b err=%0b want 0/0", locked, err_pulse); end
    send(1, 6);
    checks++; if (locked !== 1'b1 || exp_data !== 8'd7 || err_cnt !== 16'd3 || beat_cnt !== 16'd18) begin errors++; $display("FAIL relock got locked=%0b exp=%0d errs=%0d beats=%0d want 1/7/3/18", locked, exp_data, err_cnt, beat_cnt); end
  endtask

  task automatic test_oor();
    send(1, 200);
    checks++; if (oor_pulse !== 1'b1 || err_pulse !== 1'b1 || err_cnt !== 16'd4 || exp_data !== 8'd8) begin errors++; $display("FAIL oor_locked got oor=%0b err=%0b cnt=%0d exp=%0d want 1/1/4/8", oor_pulse, err_pulse, err_cnt, exp_data); end
    send(1, 200);
    checks++; if (locked !== 1'b0 || err_cnt !== 16'd5 || beat_cnt !== 16'd20) begin errors++; $display("FAIL oor_unlock got locked=%0b cnt=%0d beats=%0d want 0/5/20", locked, err_cnt, beat_cnt); end
    send(1, 200);
    checks++; if (oor_pulse !== 1'b1 || err_pulse !== 1'b0 || err_cnt !== 16'd5) begin errors++; $display("FAIL oor_hunt got oor=%0b err=%0b cnt=%0d want 1/0/5", oor_pulse, err_pulse, err_cnt); end
    send(0, 200);
    checks++; if (oor_pulse !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL oor_idle got oor=%0b err=%0b want 0/0", oor_pulse, err_pulse); end
  endtask

  task automatic test_idle_toggle();
    for (int v = 0; v <= 4; v++) begin
      send(1, 8'(v));
      send(0, 8'hee);
      checks++; if (exp_data !== 8'(v + 1) || err_pulse !== 1'b0) begin errors++; $display("FAIL idle_hold v=%0d got exp=%0d err=%0b want %0d/0", v, exp_data, err_pulse, v + 1); end
    end
    checks++; if (locked !== 1'b1 || err_cnt !== 16'd5 || beat_cnt !== 16'd22) begin errors++; $display("FAIL idle_end got locked=%0b errs=%0d beats=%0d want 1/5/22", locked, err_cnt, beat_cnt); end
  endtask

  task automatic test_saturation();
    send(0, 0, 1'b1);
    checks++; if (err_cnt !== 16'd0 || beat_cnt !== 16'd0 || s_err_cnt !== 2'd0) begin errors++; $display("FAIL clr got errs=%0d beats=%0d sat=%0d want 0/0/0", err_cnt, beat_cnt, s_err_cnt); end
    send(1, 9); send(1, 6);
    send(1, 9); send(1, 8);
    send(1, 0); send(1, 10);
    send(1, 5); send(1, 1);
    checks++; if (s_err_cnt !== 2'd3 || err_cnt !== 16'd4) begin errors++; $display("FAIL sat_four got sat=%0d errs=%0d want 3/4", s_err_cnt, err_cnt); end
    send(1, 7); send(1, 3);
    checks++; if (s_err_cnt !== 2'd3 || err_cnt !== 16'd5 || beat_cnt !== 16'd10 || s_beat_cnt !== 2'd3) begin errors++; $display("FAIL sat_five got sat=%0d errs=%0d beats=%0d sbeats=%0d want 3/5/10/3", s_err_cnt, err_cnt, beat_cnt, s_beat_cnt); end
    send(1, 9, 1'b1);
    checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd0 || s_err_cnt !== 2'd0 || beat_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins got err=%0b errs=%0d sat=%0d beats=%0d want 1/0/0/0", err_pulse, err_cnt, s_err_cnt, beat_cnt); end
  endtask

  task automatic test_async_reset();
    send(1, 5);
    checks++; if (locked !== 1'b1 || exp_data !== 8'd6 || beat_cnt !== 16'd1) begin errors++; $display("FAIL pre_rst got locked=%0b exp=%0d beats=%0d want 1/6/1", locked, exp_data, beat_cnt); end
    #2 sys_rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || exp_data !== 8'd0 || beat_cnt !== 16'd0 || err_pulse !== 1'b0) begin errors++; $display("FAIL async_rst got locked=%0b exp=%0d beats=%0d err=%0b want 0/0/0/0", locked, exp_data, beat_cnt, err_pulse); end
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    send(1, 0);
    checks++; if (locked !== 1'b0 || exp_data !== 8'd1) begin errors++; $display("FAIL post_rst got locked=%0b exp=%0d want 0/1", locked, exp_data); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_double_err();
    test_oor();
    test_idle_toggle();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrap_seq_checker.md
# wrap_seq_checker

Receive-side checker for the wrapping counter stream (0..MAX_VAL, +1 per valid beat) that the stimulus generators in this codebase emit as ivalid/idata. It locks onto the sequence, tracks the expected next value and flags every out-of-sequence beat. It keeps saturating error and beat counters for the bench or a status register. It sits directly at the consumer end of the generator's registered valid/data output.

## Interface
- DATA_WIDTH, 8, width of idata
- MAX_VAL, 10, last value before wrap to 0; must be < 2**DATA_WIDTH
- CNT_WIDTH, 16, width of err_cnt and beat_cnt
- LOCK_THRESH, 3, consecutive in-sequence beats needed to lock (>= 1)
- UNLOCK_THRESH, 2, consecutive mismatches while locked that drop lock (>= 1)

Ports:
- sys_clk  in  1  single clock, rising edge
- sys_rst  in  1  asynchronous, active-high reset
- ivalid  in  1  idata qualifies this cycle (no backpressure)
- idata  in  DATA_WIDTH  stream value
- clr_cnt  in  1  synchronous clear of err_cnt/beat_cnt
- locked  out  1  state is LOCKED or SLIP
- err_pulse  out  1  one-cycle pulse per counted mismatch
- oor_pulse  out  1  one-cycle pulse when a valid beat has idata > MAX_VAL
- exp_data  out  DATA_WIDTH  currently expected next value
- err_cnt  out  CNT_WIDTH  saturating count of err_pulse events
- beat_cnt  out  CNT_WIDTH  saturating count of valid beats accepted while locked

## Operation
- next(x) = (x == MAX_VAL) ? 0 : x + 1; DATA_WIDTH arithmetic, no overflow past MAX_VAL.
- Only cycles with ivalid=1 advance anything; ivalid=0 holds all state.
- HUNT: in-range beat -> exp_data=next(idata), good_run=1, go SYNC (to LOCKED directly if LOCK_THRESH=1). Out-of-range -> oor_pulse, stay.
- SYNC: idata==exp_data -> good_run+1, exp_data=next; when good_run reaches LOCK_THRESH -> LOCKED. Mismatch, in range -> reseed exp_data=next(idata), good_run=1, stay SYNC. Out of range -> oor_pulse, HUNT.
- LOCKED: match -> exp_data=next, beat_cnt+1. Mismatch -> err_pulse, err_cnt+1, beat_cnt+1, exp_data=next(exp_data) (assume beat consumed), bad_run=1, go SLIP (HUNT if UNLOCK_THRESH=1).
- SLIP: match -> LOCKED, bad_run=0. Mismatch -> err_pulse, counts as in LOCKED, bad_run+1; reaching UNLOCK_THRESH -> HUNT.
- Out-of-range beat in LOCKED/SLIP: oor_pulse and err_pulse both asserted; treated as mismatch.
- No errors counted in HUNT/SYNC.
- Counters saturate at all-ones, never wrap. clr_cnt in the same cycle as an increment: clear wins, result 0.
- Async reset at any time: immediate return to reset values, stream state discarded.

## Timing
- Reset values: state HUNT, locked=0, err_pulse=0, oor_pulse=0, exp_data=0, err_cnt=0, beat_cnt=0, good_run=bad_run=0.
- All outputs registered; the effect of a beat sampled at edge N is visible after edge N.
- locked rises after the edge sampling the LOCK_THRESH-th consecutive good beat. It falls after the edge sampling the UNLOCK_THRESH-th consecutive mismatch.
- err_pulse/oor_pulse high exactly one cycle per offending beat; back-to-back bad beats give back-to-back pulses.
- Throughput: one beat per clock, no stall.

## Structure
- Shared package/header: state encodings (HUNT, SYNC, LOCKED, SLIP, 2-bit), default MAX_VAL, next-value function.
- One sub-module: sat_counter (parameter WIDTH; inc, clr inputs; saturating), instantiated for err_cnt and beat_cnt.
- good_run/bad_run widths: $clog2(threshold+1).

## Test plan
- Reset then stream 0,1,2,...,10,0,1 every cycle -> locked rises after beat "2", err_cnt=0, exp_data wraps 10->0, beat_cnt = beats after lock.
- Locked stream, inject single wrong value 7 in place of 5 -> one err_pulse, err_cnt=1, SLIP then LOCKED on the next value 6, locked stays 1.
- Locked stream, two consecutive wrong beats -> err_cnt=2, locked falls, HUNT; resume a valid sequence -> relock after 3 good beats.
- idata=200 (> MAX_VAL) in HUNT -> oor_pulse, no err_cnt change. Same value while locked -> oor_pulse and err_pulse together.
- ivalid toggling 1/0 with a correct sequence -> no errors; exp_data holds during idle cycles.
- CNT_WIDTH=2, five errors -> err_cnt saturates at 3. clr_cnt coincident with an error -> 0. sys_rst asserted mid-stream -> all outputs 0 without waiting for a clock edge.
